// File: rtl/bch_32_bits_seq_ctrl.sv
// bch_32_bits_seq_ctrl
//
// Area-reduced sequencer for the 32-bit BCH(15,7) protected path. One shared
// combinational BCH(15,7) double-error-correcting decoder is time-multiplexed
// over the five blocks of a 72-bit protected word, one block per cycle. The
// corrected data bits are assembled into a 32-bit word, and the per-block
// error flags are OR-reduced.
//
// Code: systematic BCH(15,7), g(x) = x^8+x^7+x^6+x^4+1, data in bits [14:8].
// Block 4 is shortened to 12 bits and zero-padded to 15 at the top.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous reset, active-high
//   in_valid       in   data_in is valid
//   in_ready       out  controller can accept a word (IDLE)
//   data_in        in   72-bit protected word
//   out_valid      out  codeword_out / error_detected are valid (DONE)
//   out_ready      in   consumer accepts the output
//   codeword_out   out  32-bit corrected data
//   error_detected out  at least one block reported an error
//   err_count      out  saturating count of error words; only with BCH_ERR_COUNT_EN
//
// Optional feature macro: BCH_ERR_COUNT_EN (adds err_count port and counter).

module bch_32_bits_seq_ctrl #(
  parameter int unsigned NUM_BLK   = 5,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [71:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] codeword_out,
  output logic        error_detected
`ifdef BCH_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  if (NUM_BLK != 5 || ERR_CNT_W == 0) begin : g_param_check
    $error("bch_32_bits_seq_ctrl: NUM_BLK must be 5 and ERR_CNT_W nonzero");
  end

  localparam logic [2:0] LastBlk = 3'(NUM_BLK - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDecode = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  blk_idx_q, blk_idx_d;
  logic [71:0] data_q, data_d;
  logic [27:0] acc_q, acc_d;
  logic        err_acc_q, err_acc_d;
  logic [31:0] cw_q, cw_d;
  logic        err_q, err_d;

  // ---------------------------------------------------------------------------
  // GF(16) arithmetic, primitive polynomial x^4 + x + 1
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] gf_mul_a(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'b0011 : 4'b0000);
  endfunction

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] t;
    p = 4'h0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = gf_mul_a(t);
    end
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // Block slice mux
  // ---------------------------------------------------------------------------
  logic [14:0] slice;

  always_comb begin
    slice = 15'h0;
    case (blk_idx_q)
      3'd0:    slice = data_q[14:0];
      3'd1:    slice = data_q[29:15];
      3'd2:    slice = data_q[44:30];
      3'd3:    slice = data_q[59:45];
      3'd4:    slice = {3'b000, data_q[71:60]};
      default: slice = 15'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared combinational decoder
  // Syndromes S1 = r(a), S3 = r(a^3). Position i (X = a^i) is in error when
  // S1*X^2 + S1^2*X + S1^3 + S3 == 0 with S1 != 0; this is the error-locator
  // equation scaled by S1 and covers the single- and double-error cases.
  // ---------------------------------------------------------------------------
  logic [3:0]  s1, s3, pw1, pw3;
  logic [3:0]  s1_sq, c0, x_pos, loc;
  logic [14:0] flip;
  logic [14:0] corrected;
  logic        dec_err;

  always_comb begin
    s1    = 4'h0;
    s3    = 4'h0;
    pw1   = 4'h1;
    pw3   = 4'h1;
    for (int i = 0; i < 15; i++) begin
      if (slice[i]) begin
        s1 = s1 ^ pw1;
        s3 = s3 ^ pw3;
      end
      pw1 = gf_mul_a(pw1);
      pw3 = gf_mul_a(gf_mul_a(gf_mul_a(pw3)));
    end

    s1_sq = gf_mul(s1, s1);
    c0    = gf_mul(s1_sq, s1) ^ s3;
    x_pos = 4'h1;
    loc   = 4'h0;
    flip  = 15'h0;
    for (int i = 0; i < 15; i++) begin
      loc     = gf_mul(s1, gf_mul(x_pos, x_pos)) ^ gf_mul(s1_sq, x_pos) ^ c0;
      flip[i] = (s1 != 4'h0) && (loc == 4'h0);
      x_pos   = gf_mul_a(x_pos);
    end

    corrected = slice ^ flip;
    dec_err   = (s1 != 4'h0) || (s3 != 4'h0);
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    blk_idx_d = blk_idx_q;
    data_d    = data_q;
    acc_d     = acc_q;
    err_acc_d = err_acc_q;
    cw_d      = cw_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d    = data_in;
          blk_idx_d = 3'd0;
          acc_d     = 28'h0;
          err_acc_d = 1'b0;
          state_d   = StDecode;
        end
      end

      StDecode: begin
        err_acc_d = err_acc_q | dec_err;
        case (blk_idx_q)
          3'd0:    acc_d[6:0]   = corrected[14:8];
          3'd1:    acc_d[13:7]  = corrected[14:8];
          3'd2:    acc_d[20:14] = corrected[14:8];
          3'd3:    acc_d[27:21] = corrected[14:8];
          default: acc_d        = acc_q;
        endcase
        if (blk_idx_q == LastBlk) begin
          // Outputs are loaded on the same edge as the move to DONE.
          cw_d      = {corrected[11:8], acc_q};
          err_d     = err_acc_q | dec_err;
          blk_idx_d = 3'd0;
          state_d   = StDone;
        end else begin
          blk_idx_d = blk_idx_q + 3'd1;
        end
      end

      StDone: begin
        if (out_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      blk_idx_q <= 3'd0;
      data_q    <= 72'h0;
      acc_q     <= 28'h0;
      err_acc_q <= 1'b0;
      cw_q      <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_idx_q <= blk_idx_d;
      data_q    <= data_d;
      acc_q     <= acc_d;
      err_acc_q <= err_acc_d;
      cw_q      <= cw_d;
      err_q     <= err_d;
    end
  end

  assign in_ready       = (state_q == StIdle);
  assign out_valid      = (state_q == StDone);
  assign codeword_out   = cw_q;
  assign error_detected = err_q;

`ifdef BCH_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == StDone && out_ready && err_q && err_cnt_q != {ERR_CNT_W{1'b1}}) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_bch_32_bits_seq_ctrl.sv
// Scoreboard bench for bch_32_bits_seq_ctrl: directed and randomized words,
// expected responses built from a reference BCH(15,7) encoder plus known
// injected error patterns of weight <= 2 per block.
module tb_bch_32_bits_seq_ctrl;

`ifdef BCH_ERR_COUNT_EN
  localparam int TbCntW = 2;
`else
  localparam int TbCntW = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] codeword_out;
  logic        error_detected;
`ifdef BCH_ERR_COUNT_EN
  logic [TbCntW-1:0] err_count;
`endif

  bch_32_bits_seq_ctrl #(
    .NUM_BLK   (5),
    .ERR_CNT_W (TbCntW)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_in        (data_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .codeword_out   (codeword_out),
    .error_detected (error_detected)
`ifdef BCH_ERR_COUNT_EN
    ,
    .err_count      (err_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] cw;
    logic        err;
    int unsigned t;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference systematic encoder: parity = (m(x) * x^8) mod g(x).
  function automatic logic [14:0] encode(input logic [6:0] m);
    logic [14:0] r;
    r = {m, 8'h00};
    for (int i = 14; i >= 8; i--) begin
      if (r[i]) r = r ^ (15'h1D1 << (i - 8));
    end
    return {m, r[7:0]};
  endfunction

  function automatic logic [71:0] clean_word(input logic [31:0] msg);
    logic [71:0] w;
    logic [14:0] b;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      b = encode(msg[7*k +: 7]);
      w[15*k +: 15] = b;
    end
    b = encode({3'b000, msg[31:28]});
    w[71:60] = b[11:0];
    return w;
  endfunction

  // Up to maxerr distinct flipped bits in each block (block 4 has 12 real bits).
  function automatic logic [71:0] rand_mask(input int maxerr);
    logic [71:0] m;
    int len, n, p1, p2;
    m = '0;
    for (int k = 0; k < 5; k++) begin
      len = (k == 4) ? 12 : 15;
      n   = $urandom_range(maxerr, 0);
      p1  = $urandom_range(len - 1, 0);
      p2  = (p1 + 1 + $urandom_range(len - 2, 0)) % len;
      if (n >= 1) m[15*k + p1] = 1'b1;
      if (n >= 2) m[15*k + p2] = 1'b1;
    end
    return m;
  endfunction

  task automatic send(input logic [71:0] w, input logic [31:0] cw, input logic e);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait", in_ready, 1'b1);
    if (!in_ready) return;
    in_valid = 1'b1;
    data_in  = w;
    sbq.push_back('{cw: cw, err: e, t: cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = 'x;
  endtask

  // Monitor: pops and compares on every output handshake.
  initial begin
    exp_t        e;
    int unsigned first_t;
    bit          prev_valid;
    int          exp_cnt;
    bit          cnt_pending;
    first_t     = 0;
    prev_valid  = 1'b0;
    exp_cnt     = 0;
    cnt_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid  = 1'b0;
        exp_cnt     = 0;
        cnt_pending = 1'b0;
      end else begin
`ifdef BCH_ERR_COUNT_EN
        if (cnt_pending) check("err_count", err_count, exp_cnt);
`endif
        cnt_pending = 1'b0;
        if (out_valid && !prev_valid) first_t = cyc + 1;
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            check("unexpected_out_valid", out_valid, 1'b0);
          end else begin
            e = sbq.pop_front();
            check("codeword_out", codeword_out, e.cw);
            check("error_detected", error_detected, e.err);
            check("latency", first_t - e.t, 6);
            if (e.err && exp_cnt < (1 << TbCntW) - 1) exp_cnt++;
            cnt_pending = 1'b1;
          end
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    logic [71:0] w;
    logic [71:0] m;
    logic [31:0] msg;
    int          guard;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_in   = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_codeword", codeword_out, 32'h0);
    check("rst_err", error_detected, 1'b0);
`ifdef BCH_ERR_COUNT_EN
    check("rst_err_count", err_count, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed words.
    send(72'h0, 32'h0, 1'b0);
    send({12'h000, {60{1'b1}}}, 32'h0FFF_FFFF, 1'b0);
    w = '0; w[18] = 1'b1;
    send(w, 32'h0, 1'b1);
    w = '0; w[46] = 1'b1; w[58] = 1'b1;
    send(w, 32'h0, 1'b1);

    // Output stall: outputs hold, new word ignored.
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    out_ready = 1'b0;
    send(clean_word(32'h1234_5678), 32'h1234_5678, 1'b0);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("stall_reach_done", out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("stall_cw", codeword_out, 32'h1234_5678);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      in_valid = (i == 3);
      data_in  = clean_word(32'hDEAD_BEEF);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 check("release_in_ready", in_ready, 1'b1);

    // Reset during decode discards the word.
    w = '0; w[3] = 1'b1;
    send(w, 32'h0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    sbq.delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    send(72'h0, 32'h0, 1'b0);

    // Five single-error words to drive the counter into saturation.
    for (int i = 0; i < 5; i++) begin
      msg = $urandom;
      w   = clean_word(msg);
      w[15 * $urandom_range(3, 0) + 3] ^= 1'b1;
      send(w, {msg[31:28], msg[27:0]}, 1'b1);
    end

    // Randomized words with 0..2 errors per block.
    for (int i = 0; i < 40; i++) begin
      msg = $urandom;
      m   = rand_mask(2);
      send(clean_word(msg) ^ m, msg, |m);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", sbq.size(), 0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bch_32_bits_seq_ctrl.md
Name: bch_32_bits_seq_ctrl

Overview:
Area-reduced sequencer for the 32-bit BCH(15,7) protected path. One shared bch_comb_top instance is time-multiplexed over the five 15-bit blocks of a 72-bit protected word, one block per cycle. Corrected data bits are assembled into the 32-bit output word, and the per-block error flags are OR-reduced. The block sits between the protected-memory read port and the consumer, with valid/ready handshakes on both sides.

Parameters:
NUM_BLK, 5, number of blocks per word; fixed at 5, and any other value fails elaboration.
ERR_CNT_W, 16, width of the optional error-word counter.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  asynchronous reset, active-high.
in_valid  in  1  data_in is valid.
in_ready  out  1  controller can accept a word.
data_in  in  72  protected word (4x15-bit blocks + 1x12-bit block).
out_valid  out  1  codeword_out and error_detected are valid.
out_ready  in  1  consumer accepts the output.
codeword_out  out  32  corrected data.
error_detected  out  1  at least one block reported an error.
err_count  out  ERR_CNT_W  words with an error; present only with BCH_ERR_COUNT_EN.

Behaviour:
- Reset values (async, rst=1): state=IDLE, blk_idx=0, in_ready=1, out_valid=0, codeword_out=0, error_detected=0, err_count=0.
- States:
  - IDLE: in_ready=1. When in_valid=1, register data_in and go to DECODE with blk_idx=0; clear the accumulated error flag and data register.
  - DECODE: in_ready=0, out_valid=0. Each cycle the mux drives the shared decoder with slice blk_idx.
  - DONE: out_valid=1, in_ready=0. Outputs are held stable until out_ready=1, then go to IDLE.
- Slices:
  - blk 0..3 = data_in[15k+14:15k].
  - blk 4 = {3'b000, data_in[71:60]}.
- Per decode cycle: register corrected[14:8] into codeword bits [7k+6:7k] for k=0..3. For k=4, register corrected[11:8] into bits [31:28]. Accumulate err |= error_flag.
- After blk_idx=4, go to DONE. codeword_out and error_detected are loaded on the same edge.
- Latency: handshake at edge t; decode cycles t+1..t+5; out_valid high from t+6.
- Throughput: at most 1 word per 7 cycles with out_ready tied high.
- Acceptance rules:
  - No new word is accepted in DECODE or DONE; in_valid there is ignored and data_in need not be held.
  - out_valid and out_ready handshake in DONE → next cycle IDLE with in_ready=1. There is no same-cycle accept.
- Decoder path is purely combinational from the slice register to the result capture. There is no pipeline register inside the loop.
- Reset mid-DECODE or mid-DONE: the word is discarded with no output pulse; after release the state is IDLE.
- X on data_in while the state is not IDLE must not propagate to the outputs.

Optional Feature:
BCH_ERR_COUNT_EN:
- Defined:
  - err_count port exists.
  - Increments by 1 on each DONE→IDLE handshake where error_detected=1.
  - Saturates at 2^ERR_CNT_W-1 with no wrap.
  - Reset to 0 only by rst.
- Undefined: the port and the counter are absent, and the rest of the behaviour is identical.

Test Plan:
- data_in=72'h0, in_valid pulse, out_ready=1 → out_valid asserts exactly 6 cycles after the handshake; codeword_out=32'h0, error_detected=0, out_valid high for 1 cycle.
- data_in[59:0] all ones, [71:60]=0 → codeword_out=32'h0FFF_FFFF, error_detected=0.
- data_in=72'h0 with bit 18 flipped (blk 1, single error) → codeword_out=32'h0, error_detected=1. With BCH_ERR_COUNT_EN: err_count goes 0→1 after the output handshake.
- data_in=72'h0 with bits 46 and 58 flipped (two errors in blk 3) → codeword_out=32'h0, error_detected=1.
- out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0, and an in_valid pulse with a different word is ignored. Release out_ready → in_ready=1 on the next cycle.
- Assert rst at decode cycle 3 → out_valid=0 and in_ready=1 immediately. A following word of 72'h0 decodes normally with 6-cycle latency. With ERR_CNT_W=2, 5 error words → err_count holds at 3.
